// File: rtl/sync_ctrl_pkg.sv
// Package: sync_ctrl_pkg
// Purpose: shared types and constants for the serial frame-sync controller.
//   state_t     : controller states HUNT / CAPTURE / VERIFY
//   det_state_t : progress of the 1010 sync-word detector
//   SYNC_WORD   : 4-bit sync pattern, sent MSB first
//   sync_bit()  : expected sync bit for verify position k (k=0 is the MSB)
// Optional feature macro used by the controller: SYNC_PARITY_EN
package sync_ctrl_pkg;

  localparam int SYNC_LEN = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1010;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    VERIFY  = 2'd2
  } state_t;

  // Each state names the longest sync-word prefix seen so far
  typedef enum logic [1:0] {
    DET_IDLE = 2'd0,
    DET_1    = 2'd1,
    DET_10   = 2'd2,
    DET_101  = 2'd3
  } det_state_t;

  // Bit k of the sync word counted from the MSB, since the word is sent MSB first
  function automatic logic sync_bit(input logic [1:0] k);
    return |(SYNC_WORD & (4'b1000 >> k));
  endfunction

endpackage

// File: rtl/sync_detector.sv
// Module: sync_detector
// Purpose: Mealy detector for the overlapping sync word 1010 on a serial stream.
// Ports:
//   CK      in  clock, posedge
//   RESET_N in  synchronous active-low reset (returns to idle)
//   EN      in  advance the detector on this cycle's bit
//   CLR     in  synchronous clear to idle, takes priority over EN
//   X       in  serial bit
//   HIT     out combinational, high while X completes the sync word and EN is set
module sync_detector
  import sync_ctrl_pkg::*;
(
  input  logic CK,
  input  logic RESET_N,
  input  logic EN,
  input  logic CLR,
  input  logic X,
  output logic HIT
);

  det_state_t state;
  det_state_t state_next;

  // On a hit, the trailing "10" can start the next sync word, so move to DET_10
  always_comb begin
    state_next = state;
    HIT        = 1'b0;
    case (state)
      DET_IDLE: state_next = X ? DET_1 : DET_IDLE;
      DET_1:    state_next = X ? DET_1 : DET_10;
      DET_10:   state_next = X ? DET_101 : DET_IDLE;
      DET_101: begin
        state_next = X ? DET_1 : DET_10;
        HIT        = EN & ~CLR & ~X;
      end
      default:  state_next = DET_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RESET_N || CLR) begin
      state <= DET_IDLE;
    end else if (EN) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/serial_sync_ctrl.sv
// Module: serial_sync_ctrl
// Purpose: frame-synchronisation controller. Hunts for sync word 1010, captures
//   PAYLOAD_W payload bits per frame, verifies the following sync word, and
//   keeps or drops lock with a flywheel of MAX_MISS consecutive bad sync words.
// Ports:
//   CK        in   clock, posedge
//   RESET_N   in   synchronous active-low reset
//   BIT_EN    in   X is valid this cycle; state advances only when set
//   X         in   serial data bit, MSB first
//   DATA      out  last captured payload word, held until the next capture
//   VALID     out  one-cycle pulse when DATA updates
//   LOCKED    out  a sync word verified at its expected position since the last hunt
//   MISS_CNT  out  consecutive missed sync words
//   PERR      out  one-cycle parity-failure pulse (only with SYNC_PARITY_EN)
// Macro SYNC_PARITY_EN: each frame carries one even-parity bit after the payload.
module serial_sync_ctrl
  import sync_ctrl_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int MAX_MISS  = 3
) (
  input  logic                 CK,
  input  logic                 RESET_N,
  input  logic                 BIT_EN,
  input  logic                 X,
  output logic [PAYLOAD_W-1:0] DATA,
  output logic                 VALID,
  output logic                 LOCKED,
`ifdef SYNC_PARITY_EN
  output logic [3:0]           MISS_CNT,
  output logic                 PERR
`else
  output logic [3:0]           MISS_CNT
`endif
);

  localparam int CW = $clog2(PAYLOAD_W + 1);
  localparam logic [CW-1:0] LAST_SYNC  = CW'(SYNC_LEN - 1);
  localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISS);

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic          sync_bad;
  logic          hit;
  logic          det_en;
  logic          det_clr;
  logic          verify_bad;
  logic [3:0]    miss_inc;

`ifdef SYNC_PARITY_EN
  localparam logic [CW-1:0] PARITY_IDX = CW'(PAYLOAD_W);
  // Full word is kept so the parity bit can be checked before DATA updates
  logic [PAYLOAD_W-1:0] shift;
  logic [PAYLOAD_W-1:0] word_next;
  assign word_next = {shift[PAYLOAD_W-2:0], X};
`else
  localparam logic [CW-1:0] LAST_PAYLOAD = CW'(PAYLOAD_W - 1);
  // Only the first PAYLOAD_W-1 bits need storing; the last arrives with the capture edge
  logic [PAYLOAD_W-2:0] shift;
  logic [PAYLOAD_W-1:0] word_next;
  assign word_next = {shift, X};
`endif

  // The detector only runs while hunting and sits cleared otherwise, so it always
  // starts from idle when a hunt begins
  assign det_en  = BIT_EN && (state == HUNT);
  assign det_clr = (state != HUNT);

  sync_detector u_det (
    .CK      (CK),
    .RESET_N (RESET_N),
    .EN      (det_en),
    .CLR     (det_clr),
    .X       (X),
    .HIT     (hit)
  );

  assign verify_bad = sync_bad | (X != sync_bit(bit_cnt[1:0]));
  assign miss_inc   = (MISS_CNT >= MISS_LIMIT) ? MISS_LIMIT : MISS_CNT + 4'd1;

  // Controller: counts bits through capture and verify, and owns all outputs
  always_ff @(posedge CK) begin
    if (!RESET_N) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      shift    <= '0;
      sync_bad <= 1'b0;
      DATA     <= '0;
      VALID    <= 1'b0;
      LOCKED   <= 1'b0;
      MISS_CNT <= 4'd0;
`ifdef SYNC_PARITY_EN
      PERR     <= 1'b0;
`endif
    end else begin
      VALID <= 1'b0;
`ifdef SYNC_PARITY_EN
      PERR  <= 1'b0;
`endif
      if (BIT_EN) begin
        case (state)
          HUNT: begin
            if (hit) begin
              state   <= CAPTURE;
              bit_cnt <= '0;
            end
          end
          CAPTURE: begin
`ifdef SYNC_PARITY_EN
            if (bit_cnt == PARITY_IDX) begin
              bit_cnt  <= '0;
              sync_bad <= 1'b0;
              if (^{shift, X} == 1'b0) begin
                DATA  <= shift;
                VALID <= 1'b1;
                state <= VERIFY;
              end else begin
                // A bad parity bit counts as a miss, with the same drop-lock rule
                PERR <= 1'b1;
                if (miss_inc == MISS_LIMIT) begin
                  state    <= HUNT;
                  LOCKED   <= 1'b0;
                  MISS_CNT <= 4'd0;
                end else begin
                  MISS_CNT <= miss_inc;
                  state    <= VERIFY;
                end
              end
            end else begin
              shift   <= word_next;
              bit_cnt <= bit_cnt + 1'b1;
            end
`else
            shift <= word_next[PAYLOAD_W-2:0];
            if (bit_cnt == LAST_PAYLOAD) begin
              DATA     <= word_next;
              VALID    <= 1'b1;
              state    <= VERIFY;
              bit_cnt  <= '0;
              sync_bad <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
`endif
          end
          VERIFY: begin
            if (bit_cnt == LAST_SYNC) begin
              bit_cnt <= '0;
              if (!verify_bad) begin
                MISS_CNT <= 4'd0;
                LOCKED   <= 1'b1;
                state    <= CAPTURE;
              end else if (miss_inc == MISS_LIMIT) begin
                state    <= HUNT;
                LOCKED   <= 1'b0;
                MISS_CNT <= 4'd0;
              end else begin
                // Flywheel: keep frame timing and lock status through a bad sync
                MISS_CNT <= miss_inc;
                state    <= CAPTURE;
              end
            end else begin
              sync_bad <= verify_bad;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
